// File: rtl/frame_pos_scheduler_if.sv
// Bus between the position source/monitor side and the frame position scheduler.
interface frame_pos_scheduler_if #(
    parameter int CORDW      = 10,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVLW = $clog2(FIFO_DEPTH) + 1;

    logic             i_valid;
    logic [CORDW-1:0] i_data;
    logic [CORDW-1:0] i_sx;
    logic [CORDW-1:0] i_sy;
    logic             i_clr_ovf;
    logic [CORDW-1:0] o_pos;
    logic             o_pos_update;
    logic [LVLW-1:0]  o_fifo_level;
    logic             o_fifo_full;
    logic             o_overflow;
    logic             o_busy;

    modport master (
        output i_valid, i_data, i_sx, i_sy, i_clr_ovf,
        input  o_pos, o_pos_update, o_fifo_level, o_fifo_full, o_overflow, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_sx, i_sy, i_clr_ovf,
        output o_pos, o_pos_update, o_fifo_level, o_fifo_full, o_overflow, o_busy
    );
endinterface

// File: rtl/frame_pos_scheduler.sv
// Queues position commands and applies them once per frame at vertical
// blanking, rate-limited to MAX_STEP lines per frame.
module frame_pos_scheduler #(
    parameter int CORDW      = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STEP   = 8,
    parameter int POS_MAX    = 479,
    parameter int POS_RESET  = 240,
    parameter int SY_COMMIT  = 480
) (
    input  logic                  i_clk,
    input  logic                  n_btn_rst,
    frame_pos_scheduler_if.slave  bus
);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int LVLW = PTRW + 1;

    typedef enum logic {S_IDLE, S_MOVE} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] pos_q, pos_d;
    logic [CORDW-1:0] target_q, target_d;
    logic [CORDW-1:0] mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVLW-1:0]  level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             upd_q, upd_d;
    logic             tick_q, tick_d;

    logic             full, empty, pop, push, drop;
    logic [CORDW-1:0] wdata, eff_target, diff;

    // FIFO handshake decode; a tick pop frees a slot for a coincident push
    always_comb begin
        full   = (level_q == LVLW'(FIFO_DEPTH));
        empty  = (level_q == '0);
        tick_d = (bus.i_sx == '0) && (bus.i_sy == CORDW'(SY_COMMIT));
        pop    = tick_q && (state_q == S_IDLE) && !empty;
        push   = bus.i_valid && (!full || pop);
        drop   = bus.i_valid && full && !pop;
        wdata  = (bus.i_data > CORDW'(POS_MAX)) ? CORDW'(POS_MAX) : bus.i_data;
    end

    // FIFO pointer, level and sticky overflow next-state
    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVLW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVLW'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Next-state and rate-limited step, evaluated only on the frame tick
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        target_d   = target_q;
        upd_d      = 1'b0;
        eff_target = target_q;
        diff       = '0;
        if (tick_q) begin
            if (pop) begin
                eff_target = mem_q[rd_ptr_q];
                target_d   = eff_target;
            end
            if (eff_target > pos_q) begin
                diff  = eff_target - pos_q;
                pos_d = pos_q + ((diff > CORDW'(MAX_STEP)) ? CORDW'(MAX_STEP) : diff);
            end else if (eff_target < pos_q) begin
                diff  = pos_q - eff_target;
                pos_d = pos_q - ((diff > CORDW'(MAX_STEP)) ? CORDW'(MAX_STEP) : diff);
            end
            upd_d   = (pos_d != pos_q);
            state_d = (pos_d == eff_target) ? S_IDLE : S_MOVE;
        end
    end

    // State, position and control registers
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            state_q  <= S_IDLE;
            pos_q    <= CORDW'(POS_RESET);
            target_q <= CORDW'(POS_RESET);
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            upd_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            upd_q    <= upd_d;
            tick_q   <= tick_d;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign bus.o_pos        = pos_q;
    assign bus.o_pos_update = upd_q;
    assign bus.o_fifo_level = level_q;
    assign bus.o_fifo_full  = full;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_busy       = (state_q == S_MOVE) || !empty;
endmodule
